// File: rtl/drv_pkg.sv
// Shared packet definitions for the mesh terminal driver: field widths,
// field offsets above the payload, the agent transaction struct and the packer.
package drv_pkg;

  localparam int NXT_W      = 8;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 4;
  localparam int MODE_W     = 1;
  localparam int HDR_W      = NXT_W + ROW_W + COL_W + MODE_W;
  localparam int PKT_MAX_W  = 64;
  localparam int DATO_MAX_W = PKT_MAX_W - HDR_W;

  // Header field offsets, counted upward from the first bit above the payload
  localparam int MODE_OFS = 0;
  localparam int COL_OFS  = MODE_OFS + MODE_W;
  localparam int ROW_OFS  = COL_OFS + COL_W;
  localparam int NXT_OFS  = ROW_OFS + ROW_W;

  typedef struct packed {
    logic [NXT_W-1:0]      nxt_jump;
    logic [ROW_W-1:0]      id_row;
    logic [COL_W-1:0]      id_colum;
    logic [MODE_W-1:0]     mode;
    logic [DATO_MAX_W-1:0] dato;
  } ag_dr_t;

  // Builds a pkt_w-bit packet right-aligned in a PKT_MAX_W vector; payload bits above pkt_w-HDR_W are dropped
  function automatic logic [PKT_MAX_W-1:0] pack_pkt(input ag_dr_t ag, input int unsigned pkt_w);
    logic [PKT_MAX_W-1:0] hdr;
    logic [PKT_MAX_W-1:0] body;
    logic [PKT_MAX_W-1:0] mask;
    hdr  = ({{(PKT_MAX_W-NXT_W){1'b0}}, ag.nxt_jump} << NXT_OFS)
         | ({{(PKT_MAX_W-ROW_W){1'b0}}, ag.id_row}   << ROW_OFS)
         | ({{(PKT_MAX_W-COL_W){1'b0}}, ag.id_colum} << COL_OFS)
         | ({{(PKT_MAX_W-MODE_W){1'b0}}, ag.mode}    << MODE_OFS);
    body = {{HDR_W{1'b0}}, ag.dato};
    mask = {PKT_MAX_W{1'b1}} >> (PKT_MAX_W - (pkt_w - HDR_W));
    return (hdr << (pkt_w - HDR_W)) | (body & mask);
  endfunction

endpackage

// File: rtl/drv_fifo.sv
// Show-ahead packet FIFO with registered head, occupancy and flag outputs.
// Callers must only push when ready=1 and only pop when pndng=1.
module drv_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready,
  output logic                     pndng
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt_s;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          ready_q, ready_d, pndng_q, pndng_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    rd_nxt_s = rd_ptr_q + AW'(1);

    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_nxt_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Head comes from storage when an older entry remains, otherwise straight from the incoming packet
    if (count_d == {CW{1'b0}}) begin
      head_d = {W{1'b0}};
    end else if (pop && (count_q > CW'(1))) begin
      head_d = mem_q[rd_nxt_s];
    end else if (pop || (count_q == {CW{1'b0}})) begin
      head_d = din;
    end else begin
      head_d = head_q;
    end

    ready_d = (count_d < CW'(DEPTH));
    pndng_d = (count_d != {CW{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: {W{1'b0}}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      head_q   <= {W{1'b0}};
      ready_q  <= 1'b0;
      pndng_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ready_q  <= ready_d;
      pndng_q  <= pndng_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;
  assign ready = ready_q;
  assign pndng = pndng_q;

endmodule

// File: rtl/driver.sv
// Mesh terminal driver: packs agent transactions into packets, queues them in a
// show-ahead FIFO for the mesh terminal and counts packets the mesh has taken.
module driver
  import drv_pkg::*;
#(
  parameter int pckg_sz   = 20,
  parameter int fifo_size = 4,
  parameter int row       = 2,
  parameter int column    = 2,
  parameter int drvrs     = row * column,
  parameter int id        = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  nxt_jump,
  input  logic [3:0]                  id_row,
  input  logic [3:0]                  id_colum,
  input  logic                        mode,
  input  logic [pckg_sz-18:0]         dato,
  output logic [pckg_sz-1:0]          data_out_i_in,
  output logic                        pndng_i_in,
  input  logic                        popin,
  output logic [$clog2(fifo_size):0]  count,
  output logic [15:0]                 tx_count
);

  if (pckg_sz < 18 || pckg_sz > PKT_MAX_W || fifo_size < 2 ||
      (fifo_size & (fifo_size - 1)) != 0 || id < 0 || id >= drvrs) begin : g_bad_params
    $error("driver: illegal parameter combination");
  end

  ag_dr_t             ag_s;
  logic [pckg_sz-1:0] pkt_s;
  logic               push_s, pop_s;
  logic [15:0]        tx_count_q, tx_count_d;

  always_comb begin
    ag_s.nxt_jump = nxt_jump;
    ag_s.id_row   = id_row;
    ag_s.id_colum = id_colum;
    ag_s.mode     = mode;
    ag_s.dato     = DATO_MAX_W'(dato);
    pkt_s         = pckg_sz'(pack_pkt(ag_s, pckg_sz));
    push_s        = in_valid & in_ready;
    pop_s         = popin & pndng_i_in;
    if (pop_s) begin
      tx_count_d = tx_count_q + 16'd1;
    end else begin
      tx_count_d = tx_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_count_q <= 16'd0;
    end else begin
      tx_count_q <= tx_count_d;
    end
  end

  drv_fifo #(
    .W     (pckg_sz),
    .DEPTH (fifo_size)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pkt_s),
    .dout  (data_out_i_in),
    .count (count),
    .ready (in_ready),
    .pndng (pndng_i_in)
  );

  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_driver.sv
// Self-checking bench for driver: directed scenarios plus a randomized run
// compared against a queue-based model of the terminal FIFO.
module tb_driver;

  localparam int P  = 20;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    nxt_jump = 8'd0;
  logic [3:0]    id_row = 4'd0;
  logic [3:0]    id_colum = 4'd0;
  logic          mode = 1'b0;
  logic [P-18:0] dato = '0;
  logic [P-1:0]  data_out_i_in;
  logic          pndng_i_in;
  logic          popin = 1'b0;
  logic [CW-1:0] count;
  logic [15:0]   tx_count;

  int total = 0;
  int bad = 0;

  logic [P-1:0] q[$];
  int           txc = 0;
  bit           live = 1'b0;

  driver #(.pckg_sz(P), .fifo_size(D), .row(2), .column(2), .drvrs(4), .id(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .nxt_jump(nxt_jump), .id_row(id_row), .id_colum(id_colum), .mode(mode),
    .dato(dato), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
    .popin(popin), .count(count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] ref_pkt(int nj, int r, int c, int m, int d);
    return P'(nj * (1 << (P - 8)) + r * (1 << (P - 12)) + c * (1 << (P - 16)) + m * (1 << (P - 17)) + d);
  endfunction

  // One clock: model decides what the DUT should honour from pre-edge state, then samples settle
  task automatic tick();
    bit do_push, do_pop;
    logic [P-1:0] pk;
    pk      = ref_pkt(nxt_jump, id_row, id_colum, mode, dato);
    do_push = in_valid && live && (q.size() < D);
    do_pop  = popin && (q.size() > 0);
    @(posedge clk);
    if (!reset) begin
      q.delete();
      txc  = 0;
      live = 1'b0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        txc = (txc + 1) % 65536;
      end
      if (do_push) q.push_back(pk);
      live = 1'b1;
    end
    #1;
  endtask

  task automatic set_fields(int nj, int r, int c, int m, int d);
    nxt_jump = 8'(nj);
    id_row   = 4'(r);
    id_colum = 4'(c);
    mode     = 1'(m);
    dato     = (P-17)'(d);
  endtask

  task automatic rand_fields();
    set_fields($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 1), $urandom_range(0, (1 << (P - 17)) - 1));
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0; popin = 1'b0;
    reset = 1'b0; tick();
    reset = 1'b1; tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; popin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total += 5;
      if (count !== '0) begin bad++; $display("FAIL rst_count cyc=%0d got=%0d exp=0", i, count); end
      if (pndng_i_in !== 1'b0) begin bad++; $display("FAIL rst_pndng cyc=%0d got=%b exp=0", i, pndng_i_in); end
      if (data_out_i_in !== '0) begin bad++; $display("FAIL rst_data cyc=%0d got=%h exp=0", i, data_out_i_in); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready cyc=%0d got=%b exp=0", i, in_ready); end
      if (tx_count !== 16'd0) begin bad++; $display("FAIL rst_tx cyc=%0d got=%0d exp=0", i, tx_count); end
    end
    reset = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single(string tag);
    set_fields(0, 1, 0, 1, 5);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    total += 3;
    if (pndng_i_in !== 1'b1) begin bad++; $display("FAIL %s_pndng got=%b exp=1", tag, pndng_i_in); end
    if (data_out_i_in !== 20'h0010D) begin bad++; $display("FAIL %s_data got=%h exp=0010d", tag, data_out_i_in); end
    if (count !== CW'(1)) begin bad++; $display("FAIL %s_count got=%0d exp=1", tag, count); end
  endtask

  task automatic test_fill();
    logic [P-1:0] pushed[$];
    pulse_reset();
    for (int i = 0; i < D; i++) begin
      rand_fields();
      pushed.push_back(ref_pkt(nxt_jump, id_row, id_colum, mode, dato));
      in_valid = 1'b1; tick();
    end
    total += 2;
    if (count !== CW'(D)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, D); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", in_ready); end
    rand_fields(); tick(); in_valid = 1'b0;
    total += 2;
    if (count !== CW'(D)) begin bad++; $display("FAIL fill_extra_count got=%0d exp=%0d", count, D); end
    if (data_out_i_in !== pushed[0]) begin bad++; $display("FAIL fill_extra_head got=%h exp=%h", data_out_i_in, pushed[0]); end
    for (int i = 0; i < D; i++) begin
      total++;
      if (data_out_i_in !== pushed[i]) begin bad++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, data_out_i_in, pushed[i]); end
      popin = 1'b1; tick();
    end
    popin = 1'b0;
    total += 3;
    if (tx_count !== 16'd4) begin bad++; $display("FAIL fill_tx got=%0d exp=4", tx_count); end
    if (pndng_i_in !== 1'b0) begin bad++; $display("FAIL fill_empty_pndng got=%b exp=0", pndng_i_in); end
    if (data_out_i_in !== '0) begin bad++; $display("FAIL fill_empty_data got=%h exp=0", data_out_i_in); end
  endtask

  task automatic test_simultaneous();
    logic [P-1:0] pk[3];
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      pk[i] = ref_pkt(nxt_jump, id_row, id_colum, mode, dato);
      in_valid = 1'b1;
      popin = (i == 2);
      tick();
    end
    in_valid = 1'b0; popin = 1'b0;
    total += 2;
    if (count !== CW'(2)) begin bad++; $display("FAIL sim_count got=%0d exp=2", count); end
    if (data_out_i_in !== pk[1]) begin bad++; $display("FAIL sim_head got=%h exp=%h", data_out_i_in, pk[1]); end
    popin = 1'b1; tick(); popin = 1'b0;
    total++;
    if (data_out_i_in !== pk[2]) begin bad++; $display("FAIL sim_tail got=%h exp=%h", data_out_i_in, pk[2]); end
  endtask

  task automatic test_empty_pop();
    logic [15:0] tx_before;
    popin = 1'b1; tick(); tick(); popin = 1'b0;
    tx_before = 16'(txc);
    popin = 1'b1; tick(); popin = 1'b0;
    total += 3;
    if (count !== '0) begin bad++; $display("FAIL epop_count got=%0d exp=0", count); end
    if (tx_count !== tx_before) begin bad++; $display("FAIL epop_tx got=%0d exp=%0d", tx_count, tx_before); end
    if (data_out_i_in !== '0) begin bad++; $display("FAIL epop_data got=%h exp=0", data_out_i_in); end
  endtask

  task automatic test_midrun_reset();
    for (int i = 0; i < 3; i++) begin
      rand_fields(); in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    total++;
    if (count !== CW'(3)) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    in_valid = 1'b1; popin = 1'b1; reset = 1'b0; tick();
    in_valid = 1'b0; popin = 1'b0; reset = 1'b1;
    total += 2;
    if (count !== '0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    if (pndng_i_in !== 1'b0) begin bad++; $display("FAIL mid_pndng got=%b exp=0", pndng_i_in); end
    tick();
    test_single("mid_single");
  endtask

  task automatic test_random();
    logic [P-1:0] ed;
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      in_valid = 1'($urandom_range(0, 1));
      popin    = 1'($urandom_range(0, 2) != 0);
      reset    = 1'($urandom_range(0, 59) != 0);
      tick();
      ed = (q.size() != 0) ? q[0] : '0;
      total += 5;
      if (count !== CW'(q.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, q.size()); end
      if (pndng_i_in !== (q.size() != 0)) begin bad++; $display("FAIL rnd_pndng cyc=%0d got=%b exp=%b", i, pndng_i_in, q.size() != 0); end
      if (data_out_i_in !== ed) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, data_out_i_in, ed); end
      if (in_ready !== (live && q.size() < D)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, live && q.size() < D); end
      if (tx_count !== 16'(txc)) begin bad++; $display("FAIL rnd_tx cyc=%0d got=%0d exp=%0d", i, tx_count, txc); end
    end
    reset = 1'b1; in_valid = 1'b0; popin = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_fill();
    test_simultaneous();
    test_empty_pop();
    test_midrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/driver.md
DRIVER -- requirements
Module: driver

Interface
REQ-001 Parameter pckg_sz, default 20, is the packet width in bits; minimum 18.
REQ-002 Parameter fifo_size, default 4, is the FIFO depth in packets; a power of two, at least 2.
REQ-003 Parameter row, default 2, is the number of mesh rows.
REQ-004 Parameter column, default 2, is the number of mesh columns.
REQ-005 Parameter drvrs, default row*column, is the number of terminal drivers.
REQ-006 Parameter id, default 0, is this driver's terminal index, in the range 0..drvrs-1.
REQ-007 Port clk, input, 1 bit, is the single clock; all logic SHALL be rising-edge.
REQ-008 Port reset, input, 1 bit, is the synchronous, active-low reset.
REQ-009 Port in_valid, input, 1 bit, means the agent offers a transaction.
REQ-010 Port in_ready, output, 1 bit, means the driver can accept a transaction.
REQ-011 Port nxt_jump, input, 8 bits, is the next-hop field.
REQ-012 Port id_row, input, 4 bits, is the destination row.
REQ-013 Port id_colum, input, 4 bits, is the destination column.
REQ-014 Port mode, input, 1 bit, is the routing mode (0 = row first, 1 = column first).
REQ-015 Port dato, input, pckg_sz-17 bits, is the payload.
REQ-016 Port data_out_i_in, output, pckg_sz bits, is the packet at the FIFO head, driven to the mesh terminal.
REQ-017 Port pndng_i_in, output, 1 bit, means the FIFO is non-empty and a packet is pending for the mesh.
REQ-018 Port popin, input, 1 bit, is the mesh terminal's request to pop the FIFO head.
REQ-019 Port count, output, $clog2(fifo_size)+1 bits, is the current FIFO occupancy.
REQ-020 Port tx_count, output, 16 bits, counts packets popped by the mesh.

Function
REQ-021 Packet layout SHALL be {nxt_jump[pckg_sz-1:pckg_sz-8], id_row[pckg_sz-9:pckg_sz-12], id_colum[pckg_sz-13:pckg_sz-16], mode[pckg_sz-17], dato[pckg_sz-18:0]}.
REQ-022 A push occurs in a cycle with in_valid=1 and in_ready=1; the packet is assembled from the input fields of that cycle.
REQ-023 in_ready SHALL be 1 exactly when count<fifo_size and the block is out of reset.
REQ-024 A pop occurs in a cycle with popin=1 and pndng_i_in=1; popin while empty is ignored with no state change.
REQ-025 The FIFO is show-ahead: data_out_i_in always shows the oldest stored packet, and pndng_i_in = (count!=0).
REQ-026 Latency: a packet pushed into an empty FIFO appears on data_out_i_in with pndng_i_in=1 on the next cycle.
REQ-027 After a pop, the next packet, or 0 if the FIFO is now empty, appears on the next cycle.
REQ-028 Push and pop in the same cycle both occur (FIFO non-empty, not full); count is unchanged and order is preserved.
REQ-029 When full, a push is refused through in_ready=0; a same-cycle pop does not enable a push in that cycle.
REQ-030 When empty, data_out_i_in SHALL be 0.
REQ-031 Read and write pointers wrap modulo fifo_size.
REQ-032 tx_count increments by 1 per pop and wraps at 2^16.
REQ-033 Packets are never dropped or modified; the nxt_jump field passes through unchanged.

Reset
REQ-034 While reset=0 at a rising edge: count=0, pointers=0, data_out_i_in=0, pndng_i_in=0, in_ready=0, tx_count=0.
REQ-035 Reset asserted mid-operation flushes all stored packets at that edge; no pop or push is honoured in that cycle.
REQ-036 in_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-037 A shared package drv_pkg SHALL hold the field-offset localparams and a typedef struct ag_dr_t holding nxt_jump, id_row, id_colum, mode and dato.
REQ-038 A function pack_pkt() in drv_pkg SHALL assemble ag_dr_t into a packet.
REQ-039 One sub-module, drv_fifo, SHALL implement the parameterised show-ahead FIFO; driver SHALL instantiate it and add packing, handshake and counters.

Verification
REQ-040 Reset scenario: hold reset=0 for 5 cycles, then release -> all outputs are 0 during reset, and in_ready=1 on the first cycle after release.
REQ-041 Single-packet scenario: push nxt_jump=0, id_row=1, id_colum=0, mode=1, dato=3'b101 -> next cycle pndng_i_in=1 and data_out_i_in=20'h0010D.
REQ-042 Fill scenario: push 4 packets with popin=0 -> count=4 and in_ready=0; a 5th push attempt is not accepted; pop all 4 -> FIFO order preserved and tx_count=4.
REQ-043 Simultaneous scenario: with count=2, assert push and popin together -> count stays 2, the head advances, and the new packet lands at the tail.
REQ-044 Empty-pop scenario: pulse popin with count=0 -> no change to count or tx_count, and data_out_i_in=0.
REQ-045 Mid-run reset scenario: with count=3, assert reset=0 for 1 cycle -> count=0 and pndng_i_in=0; subsequent pushes behave as in the single-packet scenario.
